// File: rtl/main_ram_ctrl.sv
// Sequencer between the CPU memory port and the asynchronous ECL main RAM.
// Optional even-parity word extension is enabled by defining RAMCTL_PARITY_EN.
module main_ram_ctrl #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned ADDR_WIDTH    = 20,
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 1
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  busy,
   output logic                  ack,
   output logic [WIDTH-1:0]      rdata,
   output logic                  parity_err,
   output logic                  _ram_cs,
   output logic                  _ram_oe,
   output logic                  _ram_w,
   output logic [ADDR_WIDTH-1:0] ram_addr,
`ifdef RAMCTL_PARITY_EN
   output logic [WIDTH:0]        ram_wdata,
   input  logic [WIDTH:0]        ram_rdata
`else
   output logic [WIDTH-1:0]      ram_wdata,
   input  logic [WIDTH-1:0]      ram_rdata
`endif
);

`ifdef RAMCTL_PARITY_EN
   localparam int unsigned RAM_W = WIDTH + 1;
`else
   localparam int unsigned RAM_W = WIDTH;
`endif
   localparam int unsigned CNT_W = 4;

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
   logic [RAM_W-1:0]       ram_wdata_q, ram_wdata_d;
   logic [WIDTH-1:0]       rdata_q, rdata_d;
   logic                   busy_q, busy_d;
   logic                   ack_q, ack_d;
   logic                   parity_err_q, parity_err_d;
   logic                   ram_cs_n_q, ram_cs_n_d;
   logic                   ram_oe_n_q, ram_oe_n_d;
   logic                   ram_w_n_q, ram_w_n_d;
`ifdef RAMCTL_PARITY_EN
   logic                   rpar_q, rpar_d;
`endif

   // Next-state, counter, datapath and registered strobe decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      rdata_d      = rdata_q;
      ack_d        = 1'b0;
      parity_err_d = 1'b0;
`ifdef RAMCTL_PARITY_EN
      rpar_d       = rpar_q;
`endif

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d    = SETUP;
               cnt_d      = SETUP_LOAD;
               we_d       = we;
               ram_addr_d = addr;
`ifdef RAMCTL_PARITY_EN
               ram_wdata_d = {^wdata, wdata};
`else
               ram_wdata_d = wdata;
`endif
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
               // Capture on the edge that releases _oe, while the RAM still drives.
               if (!we_q) begin
                  rdata_d = ram_rdata[WIDTH-1:0];
`ifdef RAMCTL_PARITY_EN
                  rpar_d  = ram_rdata[WIDTH];
`endif
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
               ack_d   = 1'b1;
`ifdef RAMCTL_PARITY_EN
               parity_err_d = !we_q && ((^rdata_q) != rpar_q);
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Strobes decoded from the next state so they leave the flops glitch-free.
      busy_d     = (state_d != IDLE);
      ram_cs_n_d = (state_d == IDLE);
      ram_w_n_d  = !((state_d == STROBE) && we_d);
      ram_oe_n_d = !((state_d == STROBE) && !we_d);
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         parity_err_q <= 1'b0;
         ram_cs_n_q   <= 1'b1;
         ram_oe_n_q   <= 1'b1;
         ram_w_n_q    <= 1'b1;
`ifdef RAMCTL_PARITY_EN
         rpar_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
         parity_err_q <= parity_err_d;
         ram_cs_n_q   <= ram_cs_n_d;
         ram_oe_n_q   <= ram_oe_n_d;
         ram_w_n_q    <= ram_w_n_d;
`ifdef RAMCTL_PARITY_EN
         rpar_q       <= rpar_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign parity_err = parity_err_q;
   assign _ram_cs    = ram_cs_n_q;
   assign _ram_oe    = ram_oe_n_q;
   assign _ram_w     = ram_w_n_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_main_ram_ctrl.sv
// Bench for main_ram_ctrl: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized traffic. Honors RAMCTL_PARITY_EN.
module tb_main_ram_ctrl;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = 20;
   localparam int S = 1, T = 2, H = 1, L = S + T + H;
`ifdef RAMCTL_PARITY_EN
   localparam int unsigned RW = WIDTH + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int unsigned RW = WIDTH;
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, we = 1'b0;
   logic [AW-1:0]    addr  = '0;
   logic [WIDTH-1:0] wdata = '0;
   logic busy, ack, parity_err, ram_cs_n, ram_oe_n, ram_w_n;
   logic [WIDTH-1:0] rdata;
   logic [AW-1:0]    ram_addr;
   logic [RW-1:0]    ram_wdata, ram_rdata;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   main_ram_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .SETUP_CYCLES(S),
                   .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
      .clk(clk), ._reset(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .ack(ack), .rdata(rdata), .parity_err(parity_err),
      ._ram_cs(ram_cs_n), ._ram_oe(ram_oe_n), ._ram_w(ram_w_n),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   // Behavioural asynchronous RAM: latches on falling _w, drives zero unless _oe low.
   logic [RW-1:0] mem [logic [AW-1:0]];
   always @(negedge ram_w_n) if (rst_n === 1'b1) mem[ram_addr] = ram_wdata;
   always @(ram_oe_n or ram_addr)
      ram_rdata = (ram_oe_n === 1'b0 && mem.exists(ram_addr)) ? mem[ram_addr] : '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   logic [WIDTH-1:0] shadow  [logic [AW-1:0]];
   bit               bad_par [logic [AW-1:0]];
   int  edge_n = 0, next_free = 0, acc_edge = 0;
   bit  have = 1'b0;
   bit  t_we, t_known, t_perr;
   logic [AW-1:0]    t_addr;
   logic [WIDTH-1:0] t_wdata, t_rdata;
   logic [WIDTH-1:0] exp_rdata = '0;
   bit  rdata_known = 1'b1;

   always begin : model
      bit rst_seen, strobe, e_ack;
      int k;
      logic [RW-1:0] e_wd;
      @(posedge clk);
      edge_n++;
      rst_seen = rst_n;
      if (!rst_seen) begin
         if (have && t_we && (edge_n - 1 - acc_edge) < L && shadow.exists(t_addr))
            shadow.delete(t_addr);
         have = 1'b0; next_free = 0; exp_rdata = '0; rdata_known = 1'b1;
      end else if (req && edge_n >= next_free) begin
         have = 1'b1; acc_edge = edge_n; next_free = edge_n + L + 1;
         t_we = we; t_addr = addr; t_wdata = wdata;
         if (we) begin
            shadow[addr] = wdata;
            if (bad_par.exists(addr)) bad_par.delete(addr);
         end else begin
            t_known = shadow.exists(addr);
            t_rdata = t_known ? shadow[addr] : '0;
            t_perr  = PAR && bad_par.exists(addr);
         end
      end
      #1;
      if (!rst_seen) begin
         chk("rst_busy", busy, 0);   chk("rst_ack", ack, 0);
         chk("rst_cs", ram_cs_n, 1); chk("rst_oe", ram_oe_n, 1); chk("rst_w", ram_w_n, 1);
         chk("rst_rdata", rdata, 0); chk("rst_addr", ram_addr, 0); chk("rst_perr", parity_err, 0);
      end else begin
         k = have ? (edge_n - acc_edge) : L + 1;
         if (have && k < L) begin
            strobe = (k >= S) && (k < S + T);
`ifdef RAMCTL_PARITY_EN
            e_wd = {^t_wdata, t_wdata};
`else
            e_wd = t_wdata;
`endif
            chk("busy", busy, 1);   chk("cs", ram_cs_n, 0); chk("ack", ack, 0);
            chk("w", ram_w_n, !(t_we && strobe));
            chk("oe", ram_oe_n, !(!t_we && strobe));
            chk("ram_addr", ram_addr, t_addr);
            chk("ram_wdata", ram_wdata, e_wd);
            chk("perr_busy", parity_err, 0);
         end else begin
            e_ack = have && (k == L);
            if (e_ack && !t_we) begin exp_rdata = t_rdata; rdata_known = t_known; end
            chk("busy", busy, 0); chk("cs", ram_cs_n, 1);
            chk("w", ram_w_n, 1); chk("oe", ram_oe_n, 1);
            chk("ack", ack, e_ack);
            if (rdata_known) chk("rdata", rdata, exp_rdata);
            if (e_ack && !t_we) begin
               if (t_known) chk("perr", parity_err, t_perr);
            end else chk("perr_idle", parity_err, 0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic txn(input bit w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      output int lat, output int wlo, output int oelo,
                      output logic [WIDTH-1:0] rd, output logic pe);
      bit got;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #2; req = 1'b0;
      lat = 0; wlo = 0; oelo = 0; got = 1'b0; rd = '0; pe = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #2;
         lat++;
         if (!ram_w_n) wlo++;
         if (!ram_oe_n) oelo++;
         if (!ram_w_n && ram_cs_n) chk("w_outside_cs", 1, 0);
         if (ack) begin got = 1'b1; rd = rdata; pe = parity_err; end
      end
      if (!got) chk("ack_timeout", 0, 1);
   endtask

   function automatic logic [RW-1:0] peek(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   logic [AW-1:0] pool [8];

   initial begin : driver
      int lat, wlo, oelo, nack;
      logic [WIDTH-1:0] rd;
      logic pe;
      logic [RW-1:0] mv;
      bit got;

      // Async reset takes effect without a clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("t1_cs", ram_cs_n, 1); chk("t1_oe", ram_oe_n, 1); chk("t1_w", ram_w_n, 1);
      chk("t1_busy", busy, 0);   chk("t1_ack", ack, 0);     chk("t1_rdata", rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #2;

      // Write 0xA5 to 0x00123.
      txn(1'b1, 20'h00123, 8'hA5, lat, wlo, oelo, rd, pe);
      chk("t2_latency", lat, 4); chk("t2_w_low", wlo, 2); chk("t2_oe_low", oelo, 0);
      mv = peek(20'h00123);
      chk("t2_ram_word", mv[WIDTH-1:0], 8'hA5);
`ifdef RAMCTL_PARITY_EN
      chk("t2_ram_par", mv[WIDTH], 0);
`endif

      // Read it back, issued in the ack cycle.
      txn(1'b0, 20'h00123, 8'h00, lat, wlo, oelo, rd, pe);
      chk("t3_latency", lat, 4); chk("t3_oe_low", oelo, 2); chk("t3_w_low", wlo, 0);
      chk("t3_rdata", rd, 8'hA5);

      // Back-to-back accept in the ack cycle, ignored req while busy.
      req = 1'b1; we = 1'b1; addr = 20'h00200; wdata = 8'h3C;
      @(posedge clk); #2;
      we = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #2;
         if (ack) got = 1'b1;
      end
      chk("t4_first_ack", got, 1);
      @(posedge clk); #2;
      chk("t4_b2b_busy", busy, 1);
      req = 1'b1; we = 1'b1; addr = 20'h00300; wdata = 8'h77;
      @(posedge clk); #2; req = 1'b0;
      nack = 0; rd = '0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         if (ack) begin nack++; rd = rdata; end
      end
      chk("t4_ack_count", nack, 1);
      chk("t4_rdata", rd, 8'h3C);
      chk("t4_ignored_write", mem.exists(20'h00300), 0);

      // Reset during write strobe.
      req = 1'b1; we = 1'b1; addr = 20'h00400; wdata = 8'h11;
      @(posedge clk); #2; req = 1'b0;
      @(posedge clk); #3;
      chk("t5_in_strobe", ram_w_n, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_cs", ram_cs_n, 1); chk("t5_w", ram_w_n, 1); chk("t5_oe", ram_oe_n, 1);
      chk("t5_busy", busy, 0);   chk("t5_ack", ack, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      nack = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         if (ack) nack++;
      end
      chk("t5_no_ack", nack, 0);
      txn(1'b0, 20'h00123, 8'h00, lat, wlo, oelo, rd, pe);
      chk("t5_read_after", rd, 8'hA5);

      // Parity: corrupt stored parity of 0x00123 by backdoor (parity build only).
`ifdef RAMCTL_PARITY_EN
      mv = mem[20'h00123];
      mv[WIDTH] = ~mv[WIDTH];
      mem[20'h00123] = mv;
      bad_par[20'h00123] = 1'b1;
      txn(1'b0, 20'h00123, 8'h00, lat, wlo, oelo, rd, pe);
      chk("t6_perr", pe, 1);
      chk("t6_rdata", rd, 8'hA5);
`else
      txn(1'b0, 20'h00123, 8'h00, lat, wlo, oelo, rd, pe);
      chk("t6_perr", pe, 0);
      chk("t6_rdata", rd, 8'hA5);
`endif
      txn(1'b0, 20'h00200, 8'h00, lat, wlo, oelo, rd, pe);
      chk("t6_clean_perr", pe, 0);
      chk("t6_clean_rdata", rd, 8'h3C);

      // Randomized traffic over a small address pool; req also toggles while busy.
      pool[0] = 20'h00123; pool[1] = 20'h00200; pool[2] = 20'h00400;
      for (int i = 3; i < 8; i++) pool[i] = AW'($urandom);
      for (int c = 0; c < 3000; c++) begin
         req   = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom_range(0, 1));
         addr  = pool[$urandom_range(0, 7)];
         wdata = WIDTH'($urandom);
         @(posedge clk); #2;
      end
      req = 1'b0;
      repeat (10) @(posedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
